// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Multi-cycle execute unit driven by the 4-bit ALUControl code of the RV32I
// ALU decoder. Operands arrive through a valid/ready handshake. The unit
// computes the result plus zero, branch-taken and illegal-code flags, and
// returns them through a second valid/ready handshake.
//
// Shifts run iteratively, one bit per clock. Define ALU_FAST_SHIFT_EN to build
// a combinational barrel shifter instead. Every code then has single-cycle
// latency, and the SHIFT state and counter are not built.
//
// Ports
//   clk        in   core clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   operands and ALUControl valid
//   in_ready   out  unit can accept an operation (IDLE only)
//   ALUControl in   4-bit operation code
//   SrcA       in   operand A
//   SrcB       in   operand B; shift amount is SrcB[SHAMT_W-1:0]
//   out_valid  out  result valid (DONE state)
//   out_ready  in   consumer accepts the result
//   ALUResult  out  registered result
//   Zero       out  registered ALUResult == 0
//   BrTaken    out  registered branch condition
//   Illegal    out  registered unassigned-code flag
// -----------------------------------------------------------------------------
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             BrTaken,
  output logic             Illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_brTaken;
  logic               r_illegal;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_eq;
  logic               w_ltS;
  logic               w_ltU;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_result;
  logic               w_brTaken;
  logic               w_illegal;
  logic               w_accept;

`ifndef ALU_FAST_SHIFT_EN
  logic               w_isShift;
  logic [SHAMT_W-1:0] r_count;
  logic               r_left;
  logic               r_fill;
  logic [WIDTH-1:0]   w_shiftNext;
`endif

  assign w_sum    = SrcA + SrcB;
  assign w_diff   = SrcA - SrcB;
  assign w_eq     = (SrcA == SrcB);
  assign w_ltS    = ($signed(SrcA) < $signed(SrcB));
  assign w_ltU    = (SrcA < SrcB);
  assign w_shamt  = SrcB[SHAMT_W-1:0];
  assign w_accept = in_valid && (r_state == IDLE);

  // Single-cycle result and flags for the captured operands. In the iterative
  // build a shift here yields SrcA, which is the final result only for shamt=0.
  always_comb begin
    w_result  = '0;
    w_brTaken = 1'b0;
    w_illegal = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    w_isShift = 1'b0;
`endif
    case (ALUControl)
      4'b0000: w_result = w_sum;
      4'b0001: begin w_result = w_diff; w_brTaken = w_eq;  end
      4'b1100: begin w_result = w_diff; w_brTaken = !w_eq; end
      4'b0101: begin w_result = {{(WIDTH-1){1'b0}}, w_ltS};  w_brTaken = w_ltS;  end
      4'b1010: begin w_result = {{(WIDTH-1){1'b0}}, !w_ltS}; w_brTaken = !w_ltS; end
      4'b0110: begin w_result = {{(WIDTH-1){1'b0}}, w_ltU};  w_brTaken = w_ltU;  end
      4'b1011: begin w_result = {{(WIDTH-1){1'b0}}, !w_ltU}; w_brTaken = !w_ltU; end
      4'b0111: w_result = SrcA ^ SrcB;
      4'b0011: w_result = SrcA | SrcB;
      4'b0010: w_result = SrcA & SrcB;
`ifdef ALU_FAST_SHIFT_EN
      4'b0100: w_result = SrcA << w_shamt;
      4'b1001: w_result = SrcA >> w_shamt;
      4'b1000: w_result = $unsigned($signed(SrcA) >>> w_shamt);
`else
      4'b0100, 4'b1001, 4'b1000: begin
        w_result  = SrcA;
        w_isShift = 1'b1;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state and handshake outputs. Only IDLE accepts work, so there is at
  // most one operation every two cycles.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
          w_nextState = DONE;
`else
          if (w_isShift && (w_shamt != '0)) w_nextState = SHIFT;
          else                              w_nextState = DONE;
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        if (r_count == SHAMT_W'(1)) w_nextState = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  // One-bit step of the active shift. The fill bit is zero for logical shifts
  // and the sign of SrcA, captured at accept, for sra.
  assign w_shiftNext = r_left ? {r_result[WIDTH-2:0], 1'b0}
                              : {r_fill, r_result[WIDTH-1:1]};
`endif

  // Result and flag registers. r_result doubles as the shift register. The
  // registers change only on accept or while shifting, so they are held for
  // as long as DONE waits on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_brTaken <= 1'b0;
      r_illegal <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      r_count   <= '0;
      r_left    <= 1'b0;
      r_fill    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_result  <= w_result;
      r_zero    <= (w_result == '0);
      r_brTaken <= w_brTaken;
      r_illegal <= w_illegal;
`ifndef ALU_FAST_SHIFT_EN
      r_count   <= w_shamt;
      r_left    <= (ALUControl == 4'b0100);
      r_fill    <= (ALUControl == 4'b1000) && SrcA[WIDTH-1];
`endif
    end
`ifndef ALU_FAST_SHIFT_EN
    else if (r_state == SHIFT) begin
      r_result <= w_shiftNext;
      r_count  <= r_count - SHAMT_W'(1);
      r_zero   <= (w_shiftNext == '0);
    end
`endif
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign BrTaken   = r_brTaken;
  assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter
// Self-checking bench for alu_iter (WIDTH=32). A table of directed vectors
// with hand-computed results, flags and latencies, plus hand-written
// sequences for backpressure, reset during a shift, and out_ready while idle.
// Shift latencies follow ALU_FAST_SHIFT_EN when it is defined for the bench.
// -----------------------------------------------------------------------------
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        BrTaken;
  logic        Illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expZero;
    logic        expBr;
    logic        expIll;
    int          shamt;
    logic        isShift;
  } vec_t;

  vec_t vecs[19];

  alu_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .BrTaken    (BrTaken),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  // Expected cycles from the accept edge to out_valid high.
  function automatic int expLatency(input logic isShift, input int shamt);
    int r;
    r = (isShift && shamt > 0) ? shamt + 1 : 1;
`ifdef ALU_FAST_SHIFT_EN
    r = 1;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation from IDLE and scrambles the inputs right after the
  // accept edge, so the result can only come from the captured operands.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready before issue", 32'(in_ready), 32'd1);
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 4'($urandom_range(0, 15));
  endtask

  // Counts cycles from the accept edge until out_valid, with a cycle budget.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid drops after handshake", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] held;

    vecs[0]  = '{"add wrap",      4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 0,  1'b0};
    vecs[1]  = '{"slt blt",       4'b0101, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b0, 0,  1'b0};
    vecs[2]  = '{"sltu bltu",     4'b0110, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0, 0,  1'b0};
    vecs[3]  = '{"sgeu bgeu",     4'b1011, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b0, 0,  1'b0};
    vecs[4]  = '{"sub bne equal", 4'b1100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 0,  1'b0};
    vecs[5]  = '{"sub beq equal", 4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 0,  1'b0};
    vecs[6]  = '{"sge bge",       4'b1010, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0, 0,  1'b0};
    vecs[7]  = '{"sra 31",        4'b1000, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 31, 1'b1};
    vecs[8]  = '{"srl 31",        4'b1001, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 31, 1'b1};
    vecs[9]  = '{"sll shamt0",    4'b0100, 32'h00000001, 32'h00000020, 32'h00000001, 1'b0, 1'b0, 1'b0, 0,  1'b1};
    vecs[10] = '{"illegal 1110",  4'b1110, 32'h12345678, 32'h00000009, 32'h00000000, 1'b1, 1'b0, 1'b1, 0,  1'b0};
    vecs[11] = '{"xor",           4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, 0,  1'b0};
    vecs[12] = '{"or",            4'b0011, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 0,  1'b0};
    vecs[13] = '{"and",           4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 0,  1'b0};
    vecs[14] = '{"sub negative",  4'b0001, 32'h00000007, 32'h00000009, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0,  1'b0};
    vecs[15] = '{"sll 4",         4'b0100, 32'h00000003, 32'h00000004, 32'h00000030, 1'b0, 1'b0, 1'b0, 4,  1'b1};
    vecs[16] = '{"sra positive",  4'b1000, 32'h40000000, 32'h00000001, 32'h20000000, 1'b0, 1'b0, 1'b0, 1,  1'b1};
    vecs[17] = '{"illegal 1111",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 0,  1'b0};
    vecs[18] = '{"illegal 1101",  4'b1101, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 0,  1'b0};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 4'b0000;
    SrcA       = '0;
    SrcB       = '0;

    // Reset state while reset is held.
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset ALUResult", ALUResult, 32'd0);
    checkOutput("reset Zero",      32'(Zero),    32'd0);
    checkOutput("reset BrTaken",   32'(BrTaken), 32'd0);
    checkOutput("reset Illegal",   32'(Illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      waitResult(lat);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(expLatency(vecs[i].isShift, vecs[i].shamt)));
      checkOutput({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({vecs[i].name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      checkOutput({vecs[i].name, " ALUResult"}, ALUResult, vecs[i].expResult);
      checkOutput({vecs[i].name, " Zero"}, 32'(Zero), 32'(vecs[i].expZero));
      checkOutput({vecs[i].name, " BrTaken"}, 32'(BrTaken), 32'(vecs[i].expBr));
      checkOutput({vecs[i].name, " Illegal"}, 32'(Illegal), 32'(vecs[i].expIll));
      consume();
    end

    // Backpressure on a shamt=0 shift: outputs hold, a second request is
    // ignored, including on the edge where out_ready completes the handshake.
    applyStimulus(4'b0100, 32'h00000001, 32'h00000020);
    waitResult(lat);
    checkOutput("bp latency", 32'(lat), 32'd1);
    held       = ALUResult;
    checkOutput("bp result", held, 32'h00000001);
    ALUControl = 4'b0000;
    SrcA       = 32'd7;
    SrcB       = 32'd8;
    in_valid   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
      checkOutput("bp in_ready low",   32'(in_ready),  32'd0);
      checkOutput("bp ALUResult held", ALUResult,      held);
      checkOutput("bp Zero held",      32'(Zero),      32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp no accept in DONE", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp second op dropped", 32'(out_valid), 32'd0);
    checkOutput("bp in_ready back",     32'(in_ready),  32'd1);

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("idle out_ready no effect", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a 20-bit shift.
    applyStimulus(4'b0100, 32'h00000001, 32'd20);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid-shift reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-shift reset ALUResult", ALUResult, 32'd0);
    checkOutput("mid-shift reset Zero", 32'(Zero), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("aborted op never completes", 32'(seen), 32'd0);
    applyStimulus(4'b0000, 32'd2, 32'd3);
    waitResult(lat);
    checkOutput("post-reset add latency", 32'(lat), 32'd1);
    checkOutput("post-reset add result", ALUResult, 32'd5);
    checkOutput("post-reset add Zero", 32'(Zero), 32'd0);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bounds the whole run in case the DUT or the bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALUControl code produced by the ALU decoder in the RV32I core.
- Takes operands through a valid/ready handshake and computes the result.
- Shifts are iterative, one bit per cycle, unless the fast-shift option is compiled in.
- Returns the result, a zero flag, a branch-taken flag and an illegal-code flag through a second valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two, 32 or 64. Shift amount SHAMT_W = $clog2(WIDTH).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and ALUControl valid.
- in_ready  output  1  unit can accept an operation.
- ALUControl  input  4  operation code, encoding listed below.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B; shift amount is SrcB[SHAMT_W-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- ALUResult  output  WIDTH  result.
- Zero  output  1  ALUResult == 0.
- BrTaken  output  1  branch condition true.
- Illegal  output  1  ALUControl code is unassigned.

Behaviour:
- Encoding:
  - 0000 add; 0001 sub (beq); 1100 sub (bne); 0101 slt (blt); 1010 sge signed (bge); 0110 sltu (bltu); 1011 sgeu (bgeu).
  - 0100 sll; 1001 srl; 1000 sra; 0111 xor; 0011 or; 0010 and.
  - 1101, 1110, 1111 are illegal.
- Compare codes return {0..., flag} in ALUResult:
  - slt/sltu: A<B, signed and unsigned respectively.
  - sge/sgeu: A>=B, signed and unsigned respectively.
- BrTaken:
  - 0001: A==B. 1100: A!=B. 0101: signed A<B. 1010: signed A>=B. 0110: unsigned A<B. 1011: unsigned A>=B.
  - All other codes: 0.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Illegal code: ALUResult=0, Zero=1, BrTaken=0, Illegal=1, single-cycle path.
- Registered outputs. ALUResult, Zero, BrTaken and Illegal are held stable while out_valid=1 and out_ready=0.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid, capture ALUControl/SrcA/SrcB.
    - Non-shift code: compute and go to DONE.
    - Shift with shamt=0: result=SrcA, go to DONE.
    - Shift with shamt>0: load shift register with SrcA, counter=shamt, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle shift one bit: sll fills 0; srl fills 0; sra fills the captured sign bit. Decrement counter; when counter reaches 1 on a shift cycle, go to DONE with the final value.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency from accept edge to out_valid high:
  - Non-shift, illegal, or shamt=0: 1 cycle.
  - Shift with shamt=N>0: N+1 cycles.
- Throughput: at most one operation per 2 cycles; no acceptance while in DONE, even if out_ready=1.
- Inputs are ignored outside IDLE. SrcA/SrcB changes after acceptance do not affect the result.
- out_ready asserted while out_valid=0 has no effect.
- Reset, asynchronous at any time including mid-SHIFT:
  - State goes to IDLE; the in-flight operation is discarded.
  - out_valid=0, ALUResult=0, Zero=0, BrTaken=0, Illegal=0, counter=0.
  - in_ready=1 from the first cycle after reset deasserts.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. Every code has 1-cycle latency; the SHIFT state and counter are not built.
- Undefined: iterative shifts as described in Behaviour.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Add wrap: ALUControl=0000, A=0xFFFFFFFF, B=1 -> out_valid 1 cycle after accept; ALUResult=0, Zero=1, BrTaken=0.
- Branch compares with A=0xFFFFFFFE (-2), B=0x00000003:
  - 0101 -> ALUResult=1, BrTaken=1.
  - 0110 -> ALUResult=0, BrTaken=0.
  - 1011 -> BrTaken=1.
  - 1100 with A=B=5 -> BrTaken=0, Zero=1.
- Iterative sra: 1000, A=0x80000000, B=31 -> out_valid exactly 32 cycles after accept (undefined macro); ALUResult=0xFFFFFFFF. Same operands with srl (1001) -> 0x00000001.
- Shift edge and backpressure: 0100, A=0x1, B=0x20 (shamt=0) -> 1-cycle latency, result 0x1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, a second in_valid is not accepted.
- Reset mid-shift: 0100, B=20; assert reset at cycle 7 -> out_valid=0 and ALUResult=0 immediately. After release, a new add of 2+3 returns 5 with no trace of the aborted op.
- Illegal code 1110 -> Illegal=1, ALUResult=0, BrTaken=0, 1-cycle latency. With ALU_FAST_SHIFT_EN defined, the sra case above completes in 1 cycle with the same result.
